// File: rtl/register_file_sb_if.sv
// Decode/writeback-side bus of the scoreboarded register file.
// Read_Data, Read_Busy and Issue_Stall are combinational; Busy_Count is registered.
interface register_file_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] Read_Register;
  logic [NUM_READ*DATA_WIDTH-1:0] Read_Data;
  logic [NUM_READ-1:0]            Read_Busy;
  logic                           Write_Enable;
  logic [ADDR_WIDTH-1:0]          Write_Register;
  logic [DATA_WIDTH-1:0]          Write_Data;
  logic                           Issue_Enable;
  logic [ADDR_WIDTH-1:0]          Issue_Register;
  logic                           Issue_Stall;
  logic [ADDR_WIDTH:0]            Busy_Count;

  modport master (
    output Read_Register, Write_Enable, Write_Register, Write_Data,
           Issue_Enable, Issue_Register,
    input  Read_Data, Read_Busy, Issue_Stall, Busy_Count
  );

  modport slave (
    input  Read_Register, Write_Enable, Write_Register, Write_Data,
           Issue_Enable, Issue_Register,
    output Read_Data, Read_Busy, Issue_Stall, Busy_Count
  );
endinterface

// File: rtl/register_file_sb.sv
// Multi-port architectural register file with write-to-read bypass and a
// per-register busy scoreboard for RAW/WAW hazard detection at decode.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  register_file_sb_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [CNT_W-1:0]      busy_cnt_next;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  wr_hits_iss;
  logic                  stall;

  // Register 0 is hardwired when ZERO_REG is set: writes and issues to it are dropped.
  assign wr_ok       = bus.Write_Enable && !((ZERO_REG != 0) && (bus.Write_Register == '0));
  assign wr_hits_iss = bus.Write_Enable && (bus.Write_Register == bus.Issue_Register);
  assign stall       = bus.Issue_Enable && busy[bus.Issue_Register] && !wr_hits_iss;
  assign iss_ok      = bus.Issue_Enable && !stall &&
                       !((ZERO_REG != 0) && (bus.Issue_Register == '0));

  assign bus.Issue_Stall = Reset_n && stall;

  // Writeback clears first, then an accepted issue sets, so the new producer wins.
  always_comb begin
    busy_next     = busy;
    busy_cnt_next = '0;
    if (wr_ok)  busy_next[bus.Write_Register] = 1'b0;
    if (iss_ok) busy_next[bus.Issue_Register] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_cnt_next = busy_cnt_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      busy           <= '0;
      bus.Busy_Count <= '0;
    end else begin
      busy           <= busy_next;
      bus.Busy_Count <= busy_cnt_next;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.Write_Register] <= bus.Write_Data;
    end
  end

  // One combinational read port per slice of the packed address/data buses.
  for (genvar g = 0; g < NUM_READ; g++) begin : g_read
    logic [ADDR_WIDTH-1:0] ra;
    logic                  is_zero;
    logic                  hit_wr;

    assign ra      = bus.Read_Register[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit_wr  = bus.Write_Enable && (bus.Write_Register == ra);

    assign bus.Read_Data[g*DATA_WIDTH +: DATA_WIDTH] =
        (!Reset_n || is_zero)       ? '0 :
        ((BYPASS != 0) && hit_wr)   ? bus.Write_Data :
                                      regs[ra];

    assign bus.Read_Busy[g] = Reset_n && !is_zero && busy[ra] && !hit_wr;
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Directed plus randomized check of register_file_sb (bypass and no-bypass
// instances driven in lockstep) against an array/scoreboard reference model.
module tb_register_file_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic Clock;
  logic Reset_n;
  int   checks;
  int   errors;

  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];

  register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_a ();
  register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_b ();

  assign bus_b.Read_Register  = bus_a.Read_Register;
  assign bus_b.Write_Enable   = bus_a.Write_Enable;
  assign bus_b.Write_Register = bus_a.Write_Register;
  assign bus_b.Write_Data     = bus_a.Write_Data;
  assign bus_b.Issue_Enable   = bus_a.Issue_Enable;
  assign bus_b.Issue_Register = bus_a.Issue_Register;

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1))
    dut_a (.Clock(Clock), .Reset_n(Reset_n), .bus(bus_a.slave));
  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(0))
    dut_b (.Clock(Clock), .Reset_n(Reset_n), .bus(bus_b.slave));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic drive(input bit we, input int wr, input logic [31:0] wd,
                       input bit ie, input int ir);
    bus_a.Write_Enable   = we;
    bus_a.Write_Register = AW'(wr);
    bus_a.Write_Data     = wd;
    bus_a.Issue_Enable   = ie;
    bus_a.Issue_Register = AW'(ir);
  endtask

  task automatic rd(input int a0, input int a1);
    bus_a.Read_Register = {AW'(a1), AW'(a0)};
  endtask

  function automatic logic [31:0] exp_read(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && bus_a.Write_Enable && int'(bus_a.Write_Register) == a) return bus_a.Write_Data;
    return m_regs[a];
  endfunction

  function automatic bit exp_stall();
    int ir = int'(bus_a.Issue_Register);
    bit wr_same = bus_a.Write_Enable && (bus_a.Write_Register == bus_a.Issue_Register);
    return bus_a.Issue_Enable && ir != 0 && m_busy[ir] && !wr_same;
  endfunction

  // Checks every combinational output, takes one edge, advances the model, checks the count.
  task automatic cycle();
    int a;
    bit st;
    int wr;
    int ir;
    #3;
    for (int i = 0; i < NR; i++) begin
      a = int'(bus_a.Read_Register[i*AW +: AW]);
      chk("rd_bypass", bus_a.Read_Data[i*DW +: DW], exp_read(a, 1'b1));
      chk("rd_nobypass", bus_b.Read_Data[i*DW +: DW], exp_read(a, 1'b0));
      chk("rd_busy", 32'(bus_a.Read_Busy[i]),
          32'(a != 0 && m_busy[a] &&
              !(bus_a.Write_Enable && int'(bus_a.Write_Register) == a)));
    end
    st = exp_stall();
    chk("issue_stall", 32'(bus_a.Issue_Stall), 32'(st));
    chk("issue_stall_b", 32'(bus_b.Issue_Stall), 32'(st));
    wr = int'(bus_a.Write_Register);
    ir = int'(bus_a.Issue_Register);
    @(posedge Clock);
    if (bus_a.Write_Enable && wr != 0) begin
      m_regs[wr] = bus_a.Write_Data;
      m_busy[wr] = 1'b0;
    end
    if (bus_a.Issue_Enable && ir != 0 && !st) m_busy[ir] = 1'b1;
    #1;
    chk("busy_count", 32'(bus_a.Busy_Count), 32'(model_count()));
    chk("busy_count_b", 32'(bus_b.Busy_Count), 32'(model_count()));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    model_clear();
    drive(1'b0, 0, '0, 1'b0, 0);
    rd(5, 7);

    // Reset state.
    #1;
    chk("reset_rd0", bus_a.Read_Data[0 +: DW], 32'h0);
    chk("reset_busy", 32'(bus_a.Read_Busy), 32'h0);
    chk("reset_stall", 32'(bus_a.Issue_Stall), 32'h0);
    chk("reset_count", 32'(bus_a.Busy_Count), 32'h0);
    @(posedge Clock);
    #1 Reset_n = 1'b1;

    // Write r5 and issue r9, then reset mid-cycle.
    drive(1'b1, 5, 32'hDEADBEEF, 1'b1, 9);
    rd(5, 9);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("r5_written", bus_a.Read_Data[0 +: DW], 32'hDEADBEEF);
    chk("r9_busy", 32'(bus_a.Read_Busy[1]), 32'h1);
    chk("count_before_rst", 32'(bus_a.Busy_Count), 32'h1);
    Reset_n = 1'b0;
    #1;
    chk("midrst_r5", bus_a.Read_Data[0 +: DW], 32'h0);
    chk("midrst_count", 32'(bus_a.Busy_Count), 32'h0);
    chk("midrst_busy", 32'(bus_a.Read_Busy), 32'h0);
    model_clear();
    @(posedge Clock);
    #1 Reset_n = 1'b1;

    // Bypass versus no bypass.
    drive(1'b1, 7, 32'h12345678, 1'b0, 0);
    rd(7, 7);
    #2;
    chk("bypass_same_cycle", bus_a.Read_Data[0 +: DW], 32'h12345678);
    chk("nobypass_same_cycle", bus_b.Read_Data[0 +: DW], 32'h0);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("nobypass_next_cycle", bus_b.Read_Data[0 +: DW], 32'h12345678);

    // Zero register.
    drive(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0);
    rd(0, 0);
    #2;
    chk("zero_stall", 32'(bus_a.Issue_Stall), 32'h0);
    chk("zero_rd_same", bus_a.Read_Data[0 +: DW], 32'h0);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("zero_rd", bus_a.Read_Data[0 +: DW], 32'h0);
    chk("zero_rbusy", 32'(bus_a.Read_Busy[0]), 32'h0);
    chk("zero_count", 32'(bus_a.Busy_Count), 32'h0);

    // Scoreboard RAW/WAW on r3.
    drive(1'b0, 0, '0, 1'b1, 3);
    rd(3, 0);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("r3_busy", 32'(bus_a.Read_Busy[0]), 32'h1);
    chk("r3_count", 32'(bus_a.Busy_Count), 32'h1);
    drive(1'b0, 0, '0, 1'b1, 3);
    #1;
    chk("r3_waw_stall", 32'(bus_a.Issue_Stall), 32'h1);
    cycle();
    drive(1'b1, 3, 32'h000000A5, 1'b0, 0);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("r3_cleared_count", 32'(bus_a.Busy_Count), 32'h0);
    chk("r3_value", bus_a.Read_Data[0 +: DW], 32'h000000A5);

    // Simultaneous write and issue to busy r4.
    drive(1'b0, 0, '0, 1'b1, 4);
    cycle();
    drive(1'b1, 4, 32'h00000055, 1'b1, 4);
    rd(4, 0);
    #2;
    chk("simul_stall", 32'(bus_a.Issue_Stall), 32'h0);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("simul_value", bus_b.Read_Data[0 +: DW], 32'h00000055);
    chk("simul_busy", 32'(bus_a.Read_Busy[0]), 32'h1);
    chk("simul_count", 32'(bus_a.Busy_Count), 32'h1);
    drive(1'b1, 4, 32'h0, 1'b0, 0);
    cycle();

    // Fill every register, then drain.
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 0, '0, 1'b1, r);
      rd(r, 32 - r);
      cycle();
      chk("fill_count", 32'(bus_a.Busy_Count), 32'(r));
    end
    for (int r = 1; r < 32; r++) begin
      drive(1'b1, r, 32'(r * 3), 1'b0, 0);
      rd(r, r - 1);
      cycle();
      chk("drain_count", 32'(bus_a.Busy_Count), 32'(31 - r));
    end

    // Random traffic; small address range raises hazard density.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-port register file with an integrated scoreboard, the successor to the fixed 32x32 two-read register file in the datapath. It holds the architectural registers, gives NUM_READ combinational read ports with write-to-read bypass, and keeps a busy bit per register so the decode stage can detect RAW and WAW hazards against in-flight writebacks. It sits between decode (issue and read side) and writeback (write side).

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0 and is never written or marked busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Read_Register  in  NUM_READ*ADDR_WIDTH  packed read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- Read_Data  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- Read_Busy  out  NUM_READ  bit i = register addressed by port i still awaits writeback
- Write_Enable  in  1  writeback strobe
- Write_Register  in  ADDR_WIDTH  writeback destination
- Write_Data  in  DATA_WIDTH  writeback value
- Issue_Enable  in  1  decode requests to mark Issue_Register busy
- Issue_Register  in  ADDR_WIDTH  destination of issuing instruction
- Issue_Stall  out  1  issue refused this cycle (WAW)
- Busy_Count  out  ADDR_WIDTH+1  number of busy bits set (registered)

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array, busy vector of 2**ADDR_WIDTH bits.
- Reset (Reset_n low, asynchronous): all registers 0, all busy bits 0, Busy_Count 0; held while Reset_n low. Combinational outputs then: Read_Data all 0, Read_Busy 0, Issue_Stall 0.
- Write: on rising Clock with Write_Enable=1, Registradores[Write_Register] <= Write_Data and busy[Write_Register] <= 0. Writing a non-busy register is legal (busy stays 0).
- Zero register (ZERO_REG=1): writes and issues to address 0 ignored; reads of 0 return 0, Read_Busy 0; Issue_Stall never asserted for address 0.
- Read (combinational): Read_Data[i] = array[addr_i]. If BYPASS=1 and Write_Enable and Write_Register==addr_i (and not the zero register), Read_Data[i] = Write_Data.
- Read_Busy[i] = busy[addr_i], forced 0 when a same-cycle write targets addr_i (regardless of BYPASS).
- Issue: accepted when Issue_Enable=1 and Issue_Stall=0; on the edge busy[Issue_Register] <= 1.
- Issue_Stall = Issue_Enable & busy[Issue_Register] & ~(Write_Enable & Write_Register==Issue_Register).
- Simultaneous write and accepted issue to the same register: data written, busy ends 1 (new producer wins).
- Stalled issue: no state change from the issue side.
- Busy_Count: updated each edge to popcount of the next busy vector; net change per cycle is -1, 0 or +1.

## Timing
- Reads, Read_Busy, Issue_Stall: zero latency, combinational from addresses and write/issue inputs.
- Write visible on array read one cycle after the edge; same cycle via bypass only.
- Busy bit set/clear and Busy_Count take effect at the edge; visible the following cycle.
- Reset deassertion: first write/issue takes effect at the first rising edge with Reset_n high.
- Reset asserted mid-operation clears everything immediately, discarding pending writes/issues of that cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert Reset_n low mid-cycle -> Read_Data for r5 = 0 immediately, Busy_Count = 0.
- Write/read/bypass: Write_Enable, r7 <= 0x12345678 while port 0 reads r7 -> Read_Data0 = 0x12345678 same cycle (BYPASS=1); with BYPASS=0 old value 0 until next cycle.
- Zero register: write 0xFFFFFFFF to r0, issue r0 -> reads 0, Read_Busy 0, Issue_Stall 0, Busy_Count unchanged.
- Scoreboard: issue r3 -> next cycle Read_Busy for r3 = 1, Busy_Count = 1; issue r3 again -> Issue_Stall = 1; write r3 = 0xA5 -> busy clears, Busy_Count = 0.
- Simultaneous: r4 busy, same cycle write r4 = 0x55 and issue r4 -> Issue_Stall 0, next cycle r4 = 0x55, busy r4 = 1, Busy_Count = 1.
- Fill: issue r1..r31 on 31 consecutive cycles -> Busy_Count = 31; then write all back -> Busy_Count counts down to 0.
